// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM read-port arbiter.
package vram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    RETURN = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_BG   = 2'd1,
    REQ_OBJ  = 2'd2,
    REQ_CPU  = 2'd3
  } req_id_t;

  localparam int          NUM_REQ          = 3;
  localparam logic [7:0]  CPU_LOCKOUT_DATA = 8'hFF;

endpackage

// File: rtl/vram_req_slot.sv
// One pending-request slot: captures address on a pulse only when empty.
module vram_req_slot #(
  parameter int ADDR_W = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              load_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              clr_in,
  output logic              pending,
  output logic [ADDR_W-1:0] addr
);

  // Clear has priority so a pulse on the clearing edge is dropped.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pending <= 1'b0;
      addr    <= '0;
    end else if (clr_in) begin
      pending <= 1'b0;
    end else if (load_in && !pending) begin
      pending <= 1'b1;
      addr    <= addr_in;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Three-way VRAM read-port arbiter (BG, OBJ, CPU) with fixed-latency read sequencing.
// Optional VRAM_ARB_CONFLICT_CNT_EN adds a saturating multi-request grant counter.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              tclk_in,
  input  logic [ADDR_W-1:0] bg_addr_in,
  input  logic              bg_addr_valid_in,
  output logic [7:0]        bg_data_out,
  output logic              bg_data_valid_out,
  input  logic [ADDR_W-1:0] obj_addr_in,
  input  logic              obj_addr_valid_in,
  output logic [7:0]        obj_data_out,
  output logic              obj_data_valid_out,
  input  logic [ADDR_W-1:0] cpu_addr_in,
  input  logic              cpu_addr_valid_in,
  output logic [7:0]        cpu_data_out,
  output logic              cpu_data_valid_out,
  input  logic              sprite_hit_in,
  input  logic              mode3_in,
  output logic [ADDR_W-1:0] vram_addr_out,
  output logic              vram_rd_out,
  input  logic [7:0]        vram_data_in,
  output logic [1:0]        grant_out,
  output logic              mem_busy_out
`ifdef VRAM_ARB_CONFLICT_CNT_EN
  ,
  output logic [15:0]       conflict_cnt_out
`endif
);

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  arb_state_t state;
  req_id_t    grant_q, win;
  logic [2:0] cnt;
  logic [7:0] data_q;

  // Slot index: 0 BG, 1 OBJ, 2 CPU (grant id = index + 1).
  logic [NUM_REQ-1:0]             pend, load, clr;
  logic [NUM_REQ-1:0][ADDR_W-1:0] in_addr, req_addr;
  logic [ADDR_W-1:0]              win_addr;
  logic                           grant_fire;

  assign in_addr = {cpu_addr_in, obj_addr_in, bg_addr_in};
  assign load    = {cpu_addr_valid_in, obj_addr_valid_in, bg_addr_valid_in};

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign clr[i] = (state == RETURN) && (grant_q == req_id_t'(2'(i + 1)));
    vram_req_slot #(.ADDR_W(ADDR_W)) u_slot (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .load_in (load[i]),
      .addr_in (in_addr[i]),
      .clr_in  (clr[i]),
      .pending (pend[i]),
      .addr    (req_addr[i])
    );
  end

  always_comb begin
    win = REQ_NONE;
    if (sprite_hit_in) begin
      if      (pend[1]) win = REQ_OBJ;
      else if (pend[0]) win = REQ_BG;
      else if (pend[2]) win = REQ_CPU;
    end else begin
      if      (pend[0]) win = REQ_BG;
      else if (pend[1]) win = REQ_OBJ;
      else if (pend[2]) win = REQ_CPU;
    end
  end

  always_comb begin
    win_addr = '0;
    case (win)
      REQ_BG:  win_addr = req_addr[0];
      REQ_OBJ: win_addr = req_addr[1];
      REQ_CPU: win_addr = req_addr[2];
      default: win_addr = '0;
    endcase
  end

  assign grant_fire   = (state == IDLE) && tclk_in && (|pend);
  assign grant_out    = grant_q;
  assign mem_busy_out = (state != IDLE) || (|pend);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state              <= IDLE;
      grant_q            <= REQ_NONE;
      cnt                <= '0;
      data_q             <= '0;
      vram_addr_out      <= '0;
      vram_rd_out        <= 1'b0;
      bg_data_out        <= '0;
      obj_data_out       <= '0;
      cpu_data_out       <= '0;
      bg_data_valid_out  <= 1'b0;
      obj_data_valid_out <= 1'b0;
      cpu_data_valid_out <= 1'b0;
    end else begin
      vram_rd_out        <= 1'b0;
      bg_data_valid_out  <= 1'b0;
      obj_data_valid_out <= 1'b0;
      cpu_data_valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_fire) begin
            grant_q <= win;
            // CPU is locked out during pixel transfer: answer without touching VRAM.
            if (win == REQ_CPU && mode3_in) begin
              data_q <= CPU_LOCKOUT_DATA;
              state  <= RETURN;
            end else begin
              vram_addr_out <= win_addr;
              vram_rd_out   <= 1'b1;
              cnt           <= LAT;
              state         <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 3'd1) begin
            data_q <= vram_data_in;
            cnt    <= '0;
            state  <= RETURN;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RETURN: begin
          case (grant_q)
            REQ_BG:  begin bg_data_out  <= data_q; bg_data_valid_out  <= 1'b1; end
            REQ_OBJ: begin obj_data_out <= data_q; obj_data_valid_out <= 1'b1; end
            REQ_CPU: begin cpu_data_out <= data_q; cpu_data_valid_out <= 1'b1; end
            default: ;
          endcase
          grant_q <= REQ_NONE;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VRAM_ARB_CONFLICT_CNT_EN
  logic multi_pend;
  assign multi_pend = (pend[0] & pend[1]) | (pend[0] & pend[2]) | (pend[1] & pend[2]);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      conflict_cnt_out <= '0;
    else if (grant_fire && multi_pend && conflict_cnt_out != 16'hFFFF)
      conflict_cnt_out <= conflict_cnt_out + 16'd1;
  end
`endif

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the PPU's single VRAM read port between three requesters:
- the background fetcher inside the background FIFO,
- the sprite fetcher,
- the CPU bus.

It latches single-cycle requests, grants one access per T-cycle slot by a mode-dependent priority, sequences the fixed-latency memory read, and routes the returned byte to the winner. It sits between the PPU's pixel-FIFO fetchers and the VRAM block, and its busy flag feeds the pixel-FIFO mode-3 timing.

## Interface
Parameters:
- `ADDR_W`, default 16: VRAM address width.
- `READ_LATENCY`, default 2: clk cycles from `vram_rd_out` pulse to valid `vram_data_in`; legal range 1..7.

Ports (one clock; reset is asynchronous and active-high):
- `clk_in` — input, 1: system clock.
- `rst_in` — input, 1: asynchronous, active-high reset.
- `tclk_in` — input, 1: one-clk T-cycle strobe; grants occur only on clk edges where it is high.
- `bg_addr_in` — input, ADDR_W: background fetcher address.
- `bg_addr_valid_in` — input, 1: background request pulse.
- `bg_data_out` — output, 8: read data.
- `bg_data_valid_out` — output, 1: one-clk return strobe.
- `obj_addr_in` — input, ADDR_W: sprite fetcher address.
- `obj_addr_valid_in` — input, 1: sprite request pulse.
- `obj_data_out` — output, 8: read data.
- `obj_data_valid_out` — output, 1: one-clk return strobe.
- `cpu_addr_in` — input, ADDR_W: CPU address.
- `cpu_addr_valid_in` — input, 1: CPU request pulse.
- `cpu_data_out` — output, 8: read data.
- `cpu_data_valid_out` — output, 1: one-clk return strobe.
- `sprite_hit_in` — input, 1: sprite fetch in progress; sprite gets priority.
- `mode3_in` — input, 1: PPU in pixel transfer; CPU locked out of VRAM.
- `vram_addr_out` — output, ADDR_W: memory address.
- `vram_rd_out` — output, 1: one-clk read strobe.
- `vram_data_in` — input, 8: memory read data.
- `grant_out` — output, 2: current owner (0 none, 1 BG, 2 OBJ, 3 CPU).
- `mem_busy_out` — output, 1: any request pending or access in flight.

## Operation
- Each requester has one pending slot holding address and flag.
  - An `*_addr_valid_in` pulse loads the slot if it is empty.
  - If the slot is already full, the pulse is ignored. Each requester keeps at most one outstanding request.
- Three states: IDLE, WAIT, RETURN.
- IDLE:
  - Acts only on a clk edge where `tclk_in` is high and at least one slot is pending.
  - Picks the winner:
    - `sprite_hit_in` high: OBJ > BG > CPU.
    - `sprite_hit_in` low: BG > OBJ > CPU.
  - Sets `grant_out` to the winner.
  - Normal access: drives `vram_addr_out` to the winner's address, pulses `vram_rd_out`, loads the latency counter with READ_LATENCY, and goes to WAIT.
  - CPU winner while `mode3_in` is high: no VRAM access. The data register is loaded with 8'hFF and the FSM goes directly to RETURN.
- WAIT:
  - The counter decrements each clk.
  - At the clk edge where the counter reaches 1, `vram_data_in` is captured into the data register and the FSM goes to RETURN.
- RETURN:
  - Drives the winner's `*_data_out` with the captured byte and pulses its `*_data_valid_out` for one clk.
  - Clears the winner's slot, sets `grant_out` to 0, and returns to IDLE.
- `*_data_out` holds its last value until the next return to that requester.
- `mem_busy_out` is combinational: (state != IDLE) OR any slot pending.
- `sprite_hit_in` and `mode3_in` are sampled only at the grant edge. Changes during WAIT do not affect the access in flight.
- A request pulse for a slot that is being cleared in RETURN on the same edge is dropped. The slot is busy until after that edge.

## Timing
- Reset values: all slots empty, state IDLE, counter 0.
- Outputs during and after reset: `vram_addr_out` 0, `vram_rd_out` 0, all `*_data_out` 8'h00, all `*_data_valid_out` 0, `grant_out` 0, `mem_busy_out` 0.
- Reset asserted mid-operation aborts the access immediately. Memory data arriving later is discarded.
- Request-to-return latency for a normal access, when the grant slot is on the edge after the request: 1 (latch) + READ_LATENCY + 1 (RETURN) clk cycles after the grant edge.
- The CPU 8'hFF path returns one clk after the grant edge.
- A new grant needs IDLE plus a `tclk_in` edge, so at most one access starts per T-cycle strobe.
- A request pulse arriving on the same edge as a grant opportunity is latched first and is considered at the next `tclk_in` strobe.

## Configuration
Macro `VRAM_ARB_CONFLICT_CNT_EN`:
- Defined:
  - Adds output port `conflict_cnt_out` [15:0].
  - The counter increments at every grant edge where two or more slots are pending.
  - It saturates at 16'hFFFF and resets to 0.
- Undefined: the port and the counter are absent. Behaviour is otherwise identical.

## Structure
- Package `vram_arb_pkg` holds:
  - enum `arb_state_t` {IDLE, WAIT, RETURN};
  - enum `req_id_t` {REQ_NONE=0, REQ_BG=1, REQ_OBJ=2, REQ_CPU=3}, which also drives `grant_out`;
  - constant `CPU_LOCKOUT_DATA` = 8'hFF.
- Sub-module `vram_req_slot`, instantiated three times: the pending address/flag register with load-if-empty and clear inputs.

## Test plan
- READ_LATENCY=2. BG pulse with addr 16'h9800, memory returns 8'h3C. Required: `vram_rd_out` pulses at the next `tclk_in` edge; `bg_data_valid_out` pulses 3 clks later with 8'h3C; `grant_out` sequence 1 then 0.
- BG and OBJ pulse on the same clk. With `sprite_hit_in`=0, BG is served first, then OBJ at the next strobe. With `sprite_hit_in`=1, OBJ is served first.
- CPU pulse with `mode3_in`=1: no `vram_rd_out`; `cpu_data_valid_out` carries 8'hFF one clk after the grant. Same pulse with `mode3_in`=0: a real read returns memory data.
- Second BG pulse while BG is outstanding: ignored, exactly one `bg_data_valid_out` pulse. `mem_busy_out` is high from latch until RETURN completes.
- `rst_in` asserted during WAIT: all outputs go to reset values immediately, and no `*_data_valid_out` pulse follows deassertion.
- With `VRAM_ARB_CONFLICT_CNT_EN` defined: three simultaneous requests. Required: `conflict_cnt_out` = 2 after all three are served.
